// File: rtl/hdegen_prog.sv
`default_nettype none
// ============================================================================
//  Module      : hdegen_prog
//  Description : Horizontal display-enable and blank generator for the
//                GSTMCU video path. A dot counter restarts on every
//                horizontal sync. Programmable compares drive a horizontal
//                visible flag and a horizontal display-enable flag; the
//                enable set can be delayed by a programmable fine-scroll
//                amount. The flags are combined with the vertical
//                qualifiers into registered blank_n / de / hde1. The length
//                of each line is captured for mode detection.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CNT_W        width of the dot counter and all compare values
//    DLY_W        width of the set-delay control (max delay 2^DLY_W-1)
//  Ports
//    m2clock_i    clock, all state updates on the rising edge
//    por_i        asynchronous active-high reset
//    ihsync_i     horizontal sync; holds the line in restart while high
//    vblank_i     vertical visible qualifier (1 = visible)
//    vde_i        vertical display enable
//    hvis_on_i    count at which the visible flag sets
//    hvis_off_i   count at which the visible flag clears
//    hde_on_i     count at which a display-enable set is requested
//    hde_off_i    count at which display enable clears
//    hde_dly_i    clocks between the set request and the actual set
//    hcount_o     current counter value
//    line_len_o   counter value captured at the last sync start
//    blank_n_o    registered hvis & vblank
//    hde1_o       registered hde
//    de_o         registered hde & vde
// ============================================================================
module hdegen_prog #(
    parameter int CNT_W = 8,
    parameter int DLY_W = 3
) (
    input  logic             m2clock_i,
    input  logic             por_i,
    input  logic             ihsync_i,
    input  logic             vblank_i,
    input  logic             vde_i,
    input  logic [CNT_W-1:0] hvis_on_i,
    input  logic [CNT_W-1:0] hvis_off_i,
    input  logic [CNT_W-1:0] hde_on_i,
    input  logic [CNT_W-1:0] hde_off_i,
    input  logic [DLY_W-1:0] hde_dly_i,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] line_len_o,
    output logic             blank_n_o,
    output logic             hde1_o,
    output logic             de_o
);

    // Number of delay stages; stage k holds the request from k clocks ago.
    localparam int               DEPTH   = (1 << DLY_W) - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] hcount_q,   hcount_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic             hsync_q;
    logic             hvis_q,     hvis_d;
    logic             hde_q,      hde_d;
    logic [DEPTH-1:0] pipe_q,     pipe_d;
    logic             blank_n_q,  blank_n_d;
    logic             hde1_q,     hde1_d;
    logic             de_q,       de_d;

    // ------------------------------------------------------------------
    // Set-request delay line
    // ------------------------------------------------------------------
    logic             w_req;
    logic             w_dreq;
    // Tap 0 is the undelayed request, tap k (k >= 1) is pipeline stage k.
    // Its width is exactly 2^DLY_W, so hde_dly_i can index it directly.
    logic [DEPTH:0]   w_taps;

    assign w_req  = (hcount_q == hde_on_i) && !ihsync_i;
    assign w_taps = {pipe_q, w_req};
    assign w_dreq = w_taps[hde_dly_i];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        hcount_d   = hcount_q;
        line_len_d = line_len_q;
        hvis_d     = hvis_q;
        hde_d      = hde_q;
        pipe_d     = pipe_q;

        // Capture the pre-clear count on the first clock of sync, which
        // may be the saturated value on an over-long line.
        if (ihsync_i && !hsync_q) begin
            line_len_d = hcount_q;
        end

        if (ihsync_i) begin
            // Restart: the whole horizontal state is held cleared,
            // including any set requests still travelling the delay line.
            hcount_d = '0;
            hvis_d   = 1'b0;
            hde_d    = 1'b0;
            pipe_d   = '0;
        end else begin
            // Saturate rather than wrap so an all-ones compare keeps
            // matching on a line that runs past the counter range.
            if (hcount_q != CNT_MAX) begin
                hcount_d = hcount_q + CNT_ONE;
            end

            // Clear has priority, so on == off leaves the flag low.
            if (hcount_q == hvis_off_i) begin
                hvis_d = 1'b0;
            end else if (hcount_q == hvis_on_i) begin
                hvis_d = 1'b1;
            end

            // A delayed set that lands on the clear count is lost.
            if (hcount_q == hde_off_i) begin
                hde_d = 1'b0;
            end else if (w_dreq) begin
                hde_d = 1'b1;
            end

            pipe_d = w_taps[DEPTH-1:0];
        end
    end

    // Output stage is deliberately outside restart: it simply follows the
    // flags and qualifiers one clock later.
    always_comb begin
        blank_n_d = hvis_q & vblank_i;
        hde1_d    = hde_q;
        de_d      = hde_q & vde_i;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge m2clock_i or posedge por_i) begin
        if (por_i) begin
            hcount_q   <= '0;
            line_len_q <= '0;
            hsync_q    <= 1'b0;
            hvis_q     <= 1'b0;
            hde_q      <= 1'b0;
            pipe_q     <= '0;
            blank_n_q  <= 1'b1;
            hde1_q     <= 1'b0;
            de_q       <= 1'b0;
        end else begin
            hcount_q   <= hcount_d;
            line_len_q <= line_len_d;
            hsync_q    <= ihsync_i;
            hvis_q     <= hvis_d;
            hde_q      <= hde_d;
            pipe_q     <= pipe_d;
            blank_n_q  <= blank_n_d;
            hde1_q     <= hde1_d;
            de_q       <= de_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hcount_o   = hcount_q;
    assign line_len_o = line_len_q;
    assign blank_n_o  = blank_n_q;
    assign hde1_o     = hde1_q;
    assign de_o       = de_q;

endmodule
`default_nettype wire

// File: tb/tb_hdegen_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdegen_prog
//  Description : Self-checking bench for hdegen_prog. A behavioural line
//                model (count, captured length, flag rules and a history of
//                set requests since the last restart) predicts every output
//                after each clock; scenario tasks add direct checks of the
//                documented widths, latencies and boundary cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdegen_prog;

    localparam int CNT_W = 8;
    localparam int DLY_W = 3;
    localparam int CMAX  = 255;

    logic             clk = 1'b0;
    logic             por = 1'b0;
    logic             ihsync = 1'b0;
    logic             vblank = 1'b1;
    logic             vde = 1'b1;
    logic [CNT_W-1:0] hvis_on = '0, hvis_off = '0, hde_on = '0, hde_off = '0;
    logic [DLY_W-1:0] hde_dly = '0;
    logic [CNT_W-1:0] hcount, line_len;
    logic             blank_n, hde1, de;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hdegen_prog #(.CNT_W(CNT_W), .DLY_W(DLY_W)) dut (
        .m2clock_i  (clk),
        .por_i      (por),
        .ihsync_i   (ihsync),
        .vblank_i   (vblank),
        .vde_i      (vde),
        .hvis_on_i  (hvis_on),
        .hvis_off_i (hvis_off),
        .hde_on_i   (hde_on),
        .hde_off_i  (hde_off),
        .hde_dly_i  (hde_dly),
        .hcount_o   (hcount),
        .line_len_o (line_len),
        .blank_n_o  (blank_n),
        .hde1_o     (hde1),
        .de_o       (de)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_cnt, m_len;
    bit m_hs, m_hvis, m_hde, m_blank, m_hde1, m_de;
    bit m_hist[$];   // set requests of past clocks in this line, [0] = newest

    function automatic void model_reset();
        m_cnt = 0; m_len = 0; m_hs = 0; m_hvis = 0; m_hde = 0;
        m_blank = 1; m_hde1 = 0; m_de = 0;
        m_hist.delete();
    endfunction

    function automatic logic [18:0] mexp();
        return {8'(m_cnt), 8'(m_len), m_blank, m_hde1, m_de};
    endfunction

    // Advance the model over one clock using the inputs now applied, then
    // let the DUT take the same edge and settle.
    task automatic tick();
        bit req, dreq, n_hvis, n_hde;
        int n_cnt, n_len, d;
        d    = int'(hde_dly);
        req  = !ihsync && (m_cnt == int'(hde_on));
        if (d == 0)                 dreq = req;
        else if (m_hist.size() >= d) dreq = m_hist[d-1];
        else                        dreq = 0;
        n_len  = (ihsync && !m_hs) ? m_cnt : m_len;
        n_cnt  = 0; n_hvis = 0; n_hde = 0;
        if (!ihsync) begin
            n_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            n_hvis = m_hvis;
            if (m_cnt == int'(hvis_off))     n_hvis = 0;
            else if (m_cnt == int'(hvis_on)) n_hvis = 1;
            n_hde = m_hde;
            if (m_cnt == int'(hde_off)) n_hde = 0;
            else if (dreq)              n_hde = 1;
        end
        m_blank = m_hvis & vblank;
        m_hde1  = m_hde;
        m_de    = m_hde & vde;
        if (ihsync) m_hist.delete();
        else begin
            m_hist.push_front(req);
            if (m_hist.size() > 8) void'(m_hist.pop_back());
        end
        m_cnt = n_cnt; m_len = n_len; m_hvis = n_hvis; m_hde = n_hde; m_hs = ihsync;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        ihsync = 0; vblank = 1; vde = 1;
        hvis_on = 8'd9; hvis_off = 8'd114; hde_on = 8'd12; hde_off = 8'd96; hde_dly = 0;
        #1 por = 1;
        #2;
        n_cmp++;
        if ({hcount, line_len, blank_n, hde1, de} !== {8'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: got %h want %h", {hcount, line_len, blank_n, hde1, de},
                     {8'd0, 8'd0, 1'b1, 1'b0, 1'b0});
        end
        model_reset();
        #1 por = 0;
    endtask

    task automatic test_visible();
        int hi = 0, first = -1;
        for (int i = 1; i <= 130; i++) begin
            tick();
            n_cmp++;
            if ({hcount, line_len, blank_n, hde1, de} !== mexp()) begin
                n_bad++;
                $display("FAIL visible_model cyc %0d: got %h want %h", i,
                         {hcount, line_len, blank_n, hde1, de}, mexp());
            end
            if (i == 1) begin
                n_cmp++;
                if (blank_n !== 1'b0) begin
                    n_bad++;
                    $display("FAIL visible_fall: got %b want 0", blank_n);
                end
            end
            if (blank_n === 1'b1) begin
                hi++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (hi != 105 || first != 11) begin
            n_bad++;
            $display("FAIL visible_width: got %0d from clk %0d want 105 from clk 11", hi, first);
        end
    endtask

    task automatic test_de_sweep();
        int dl[3] = '{0, 4, 7};
        vde = 1; hde_on = 8'd12; hde_off = 8'd96;
        foreach (dl[k]) begin
            int hi = 0, first = -1;
            hde_dly = 3'(dl[k]);
            ihsync = 1; tick(); ihsync = 0;
            for (int i = 1; i <= 120; i++) begin
                tick();
                n_cmp++;
                if ({hcount, line_len, blank_n, hde1, de} !== mexp()) begin
                    n_bad++;
                    $display("FAIL de_sweep_model d=%0d cyc %0d: got %h want %h", dl[k], i,
                             {hcount, line_len, blank_n, hde1, de}, mexp());
                end
                if (de === 1'b1) begin
                    hi++;
                    if (first < 0) first = i;
                end
            end
            n_cmp++;
            if (hi != 84 - dl[k] || first != 14 + dl[k]) begin
                n_bad++;
                $display("FAIL de_width d=%0d: got %0d from clk %0d want %0d from clk %0d",
                         dl[k], hi, first, 84 - dl[k], 14 + dl[k]);
            end
        end
        hde_dly = 0;
    endtask

    task automatic test_line_len();
        int sp[2] = '{512, 200};
        int want[2] = '{255, 199};
        foreach (sp[k]) begin
            for (int ln = 0; ln < 3; ln++) begin
                ihsync = 1; tick(); ihsync = 0;
                n_cmp++;
                if ({hcount, line_len, blank_n, hde1, de} !== mexp()) begin
                    n_bad++;
                    $display("FAIL line_model sp=%0d line %0d: got %h want %h", sp[k], ln,
                             {hcount, line_len, blank_n, hde1, de}, mexp());
                end
                if (ln >= 1) begin
                    n_cmp++;
                    if (line_len !== 8'(want[k])) begin
                        n_bad++;
                        $display("FAIL line_len sp=%0d: got %0d want %0d", sp[k], line_len, want[k]);
                    end
                end
                for (int i = 1; i < sp[k]; i++) tick();
                n_cmp++;
                if ({hcount, line_len, blank_n, hde1, de} !== mexp()) begin
                    n_bad++;
                    $display("FAIL line_end_model sp=%0d: got %h want %h", sp[k],
                             {hcount, line_len, blank_n, hde1, de}, mexp());
                end
            end
            if (k == 0) begin
                n_cmp++;
                if (hcount !== 8'd255) begin
                    n_bad++;
                    $display("FAIL hcount_saturate: got %0d want 255", hcount);
                end
            end
        end
    endtask

    task automatic test_collisions();
        int hde_hi = 0, blk_hi = 0, de_hi = 0;
        // Delayed set landing exactly on the clear count.
        vde = 1; vblank = 1; hde_on = 8'd20; hde_off = 8'd23; hde_dly = 3'd3;
        hvis_on = 8'd50; hvis_off = 8'd50;
        ihsync = 1; tick(); ihsync = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (hde1 === 1'b1)    hde_hi++;
            if (blank_n === 1'b1) blk_hi++;
        end
        n_cmp++;
        if (hde_hi != 0) begin
            n_bad++;
            $display("FAIL hde_collision: got %0d high clocks want 0", hde_hi);
        end
        n_cmp++;
        if (blk_hi != 0) begin
            n_bad++;
            $display("FAIL hvis_on_eq_off: got %0d high clocks want 0", blk_hi);
        end
        // vde low masks de but not hde1.
        vde = 0; hde_on = 8'd12; hde_off = 8'd96; hde_dly = 0; hde_hi = 0;
        ihsync = 1; tick(); ihsync = 0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (hde1 === 1'b1) hde_hi++;
            if (de === 1'b1)   de_hi++;
        end
        n_cmp++;
        if (de_hi != 0 || hde_hi != 84) begin
            n_bad++;
            $display("FAIL vde_qualifier: got de %0d hde1 %0d want de 0 hde1 84", de_hi, hde_hi);
        end
        vde = 1;
    endtask

    task automatic test_restart();
        int hi = 0;
        hde_on = 8'd12; hde_off = 8'd96; hde_dly = 0;
        ihsync = 1; tick(); ihsync = 0;
        repeat (60) tick();
        n_cmp++;
        if (hcount !== 8'd60 || hde1 !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_pre: got hcount %0d hde1 %b want 60 1", hcount, hde1);
        end
        ihsync = 1; tick();
        n_cmp++;
        if (hcount !== 8'd0) begin
            n_bad++;
            $display("FAIL restart_hcount: got %0d want 0", hcount);
        end
        ihsync = 0; tick();
        n_cmp++;
        if (hde1 !== 1'b0 || hcount !== 8'd1) begin
            n_bad++;
            $display("FAIL restart_hde1: got hde1 %b hcount %0d want 0 1", hde1, hcount);
        end
        // Restart while a delayed set is still in flight.
        hde_dly = 3'd5;
        repeat (13) tick();
        ihsync = 1; tick(); ihsync = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++;
            if ({hcount, line_len, blank_n, hde1, de} !== mexp()) begin
                n_bad++;
                $display("FAIL flush_model cyc %0d: got %h want %h", i,
                         {hcount, line_len, blank_n, hde1, de}, mexp());
            end
            if (hde1 === 1'b1) hi++;
        end
        n_cmp++;
        if (hi != 0) begin
            n_bad++;
            $display("FAIL pipeline_flush: got %0d high clocks want 0", hi);
        end
        hde_dly = 0;
    endtask

    task automatic test_midline_reset();
        ihsync = 1; tick(); ihsync = 0;
        repeat (40) tick();
        por = 1;
        #2;
        n_cmp++;
        if ({hcount, line_len, blank_n, hde1, de} !== {8'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL midline_reset: got %h want %h", {hcount, line_len, blank_n, hde1, de},
                     {8'd0, 8'd0, 1'b1, 1'b0, 1'b0});
        end
        model_reset();
        #2 por = 0;
        tick();
        n_cmp++;
        if ({hcount, line_len, blank_n, hde1, de} !== mexp()) begin
            n_bad++;
            $display("FAIL post_reset_model: got %h want %h", {hcount, line_len, blank_n, hde1, de},
                     mexp());
        end
    endtask

    task automatic test_random();
        for (int ln = 0; ln < 10; ln++) begin
            int w, len;
            hvis_on  = 8'($urandom_range(0, 200));
            hvis_off = 8'($urandom_range(0, 255));
            hde_on   = 8'($urandom_range(0, 200));
            hde_off  = 8'(int'(hde_on) + $urandom_range(0, 55));
            hde_dly  = 3'($urandom_range(0, 7));
            w   = $urandom_range(1, 3);
            len = $urandom_range(20, 320);
            ihsync = 1;
            repeat (w) tick();
            ihsync = 0;
            for (int i = 0; i < len; i++) begin
                vblank = ($urandom_range(0, 15) != 0);
                vde    = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 99) == 0) hde_dly = 3'($urandom_range(0, 7));
                tick();
                n_cmp++;
                if ({hcount, line_len, blank_n, hde1, de} !== mexp()) begin
                    n_bad++;
                    $display("FAIL random line %0d cyc %0d: got %h want %h", ln, i,
                             {hcount, line_len, blank_n, hde1, de}, mexp());
                end
            end
        end
        vblank = 1; vde = 1;
    endtask

    initial begin
        test_reset();
        test_visible();
        test_de_sweep();
        test_line_len();
        test_collisions();
        test_restart();
        test_midline_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hdegen_prog.md
# hdegen_prog

Parametrised horizontal display-enable and blank generator for the GSTMCU video path. A horizontal dot counter restarts on each horizontal sync. Programmable compare values (all in counter units) drive a horizontal-visible flag and a horizontal display-enable flag; the enable flag has a programmable fine-scroll set delay. It combines these with the vertical qualifiers to produce registered `blank_n`, `de` and `hde1`, and measures the length of each line for mode detection. The shifter and DMA sequencer consume its outputs.

## Interface
- `CNT_W`, default 8: width of the horizontal counter and of all compare values.
- `DLY_W`, default 3: width of the set-delay control; maximum delay is 2^DLY_W-1 clocks.
- `m2clock` in 1: single clock; all state updates on its rising edge.
- `por` in 1: reset, asynchronous, active-high.
- `ihsync` in 1: horizontal sync. While high, the line is held in restart.
- `vblank` in 1: vertical visible qualifier; 1 means visible.
- `vde` in 1: vertical display enable.
- `hvis_on` in CNT_W: count at which the visible flag sets.
- `hvis_off` in CNT_W: count at which the visible flag clears.
- `hde_on` in CNT_W: count at which the display-enable set is requested.
- `hde_off` in CNT_W: count at which display enable clears.
- `hde_dly` in DLY_W: number of clocks between the set request and the actual set.
- `hcount` out CNT_W: current counter value.
- `line_len` out CNT_W: counter value captured at the last sync start.
- `blank_n` out 1: registered `hvis & vblank`.
- `hde1` out 1: registered `hde`.
- `de` out 1: registered `hde & vde`.

## Operation
- **Restart.** Restart is active while `ihsync`=1. During restart:
  - `hcount`=0.
  - `hvis`=0 and `hde`=0.
  - The delay pipeline is flushed.
- **Counter.** With `ihsync`=0, `hcount` increments by 1 each clock.
  - It saturates at 2^CNT_W-1; there is no wrap.
  - Compares use the current `hcount`, so a saturated counter keeps matching a compare value of all-ones.
- **Line length.** `ihsync` is registered as `hs_d`.
  - In the cycle where `ihsync`=1 and `hs_d`=0, `line_len` <= `hcount`. This is the pre-clear value and may be the saturated value.
  - At all other times `line_len` holds.
- **Visible flag.** On the clock where `hcount`==`hvis_on`, `hvis` <= 1. On the clock where `hcount`==`hvis_off`, `hvis` <= 0.
  - If both match in the same clock, clear wins.
  - If `hvis_on`==`hvis_off`, `hvis` stays 0.
- **Display-enable set request.** `req` = (`hcount`==`hde_on`) and `ihsync`=0.
  - `req` enters a shift pipeline of depth 2^DLY_W-1.
  - The delayed request `dreq` is `req` itself when `hde_dly`=0. Otherwise it is pipeline stage `hde_dly`, so a request at count N becomes `dreq` at count N+`hde_dly`.
  - `hde_dly` is sampled combinationally at pipeline output. Changing it mid-line may drop or duplicate one set; this is permitted.
- **Display enable.** Priority order: restart, then (`hcount`==`hde_off`) clears, then `dreq` sets, then hold.
  - A delayed set that lands on the `hde_off` count is lost.
- **Outputs.** `blank_n`, `hde1` and `de` are registered from `hvis`, `hde`, `vblank` and `vde`. They are not subject to restart. Only `por` resets them.

## Timing
- **Reset values on `por`:**
  - `hcount`=0, `line_len`=0, `hs_d`=0.
  - `hvis`=0, `hde`=0, pipeline all 0.
  - `blank_n`=1, `hde1`=0, `de`=0.
- `por` takes effect immediately, without a clock. The first count occurs on the first rising edge after `por` falls with `ihsync`=0.
- **Restart timing.** With `ihsync` rising before edge k, `hcount`=0 after edge k. The first edge with `ihsync`=0 gives `hcount`=1.
- **Flag latency.** `hvis` and `hde` change on the edge where the compare is true, i.e. as `hcount` leaves value V.
- **Output latency.** `blank_n`, `hde1` and `de` follow one clock later: 1 clock from flag to pin.
- **Display-enable width.** With `hde_dly`=d, `hde` is high for (`hde_off` - `hde_on` - d) clocks when that value is > 0; otherwise it stays low.
- **Line length.** `line_len` updates on the sync-start edge and is visible the following cycle.

## Test plan
- **Visible flag.** After reset, `ihsync` low, `hvis_on`=9, `hvis_off`=114, `vblank`=1 -> `blank_n` falls one clock after reset, then is 1 for exactly 105 clocks, starting 2 clocks after `hcount` reads 9.
- **Display enable and delay sweep.** `hde_on`=12, `hde_off`=96, `vde`=1:
  - `hde_dly`=0 -> `de` high for 84 clocks.
  - `hde_dly`=4 -> `de` high for 80 clocks, rising 4 clocks later.
  - `hde_dly`=7 -> `de` high for 77 clocks.
- **Line length and saturation.** `ihsync` pulse every 512 clocks, CNT_W=8 -> `hcount` sticks at 255 and `line_len`=255. Pulses every 200 clocks -> `line_len` tracks the pulse spacing: the count reached at sync start, constant from line 2 onward.
- **Collisions and qualifier.**
  - `hde_dly`=3, `hde_off`=`hde_on`+3 -> `hde` never sets.
  - `hvis_on`=`hvis_off`=50 -> `blank_n` stays 0 while `vblank`=1.
  - `vde`=0 -> `de`=0 while `hde1` still pulses.
- **Mid-line restart.** Assert `ihsync` while `hde`=1 at `hcount`=60 -> `hcount`=0 next edge, `hde1`=0 one clock later. With `hde_on`=12 and `hde_dly`=5, a pending delayed set is flushed.
- **Mid-line reset.** Pulse `por` mid-line -> outputs asynchronously become `blank_n`=1, `hde1`=0, `de`=0, `hcount`=0 and `line_len`=0 without a clock edge.
